spi_slave_rx: RTL

- Receive-side consumer of the 12-bit SPI transmitter; sits at the far end of the sclk/cs/mosi link.
- Oversamples the serial lines in the local clk domain, deserialises one MSB-first word per chip-select frame and presents it on a valid/ready output port.
- Flags malformed frames and words that arrive while the previous word is still unaccepted.

---
 rtl/spi_slave_rx.sv | 123 ++++++++++++
 1 files changed

// File: rtl/spi_slave_rx.sv
// SPI receive endpoint: oversamples sclk/cs/mosi in the clk domain, deserialises one
// MSB-first word per chip-select frame and offers it on a valid/ready port.
module spi_slave_rx #(
  parameter int DATA_W    = 12,
  parameter int LEAD_SKIP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CW  = $clog2(DATA_W + 1);
  localparam int SKW = (LEAD_SKIP > 0) ? $clog2(LEAD_SKIP + 1) : 1;
  localparam logic [CW-1:0]  BIT_LAST  = CW'(DATA_W - 1);
  localparam logic [SKW-1:0] SKIP_LAST = (LEAD_SKIP > 0) ? SKW'(LEAD_SKIP - 1) : '0;

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, HOLD} state_t;

  logic cs_s1, cs_s2, cs_h;
  logic sclk_s1, sclk_s2, sclk_h;
  logic mosi_s1, mosi_s2;

  state_t             state;
  logic [SKW-1:0]     skip_cnt;
  logic [CW-1:0]      bit_cnt;
  logic [DATA_W-1:0]  shift_reg;

  logic cs_fall, cs_rise, sclk_fall;

  // Presets match an idle link so leaving reset never looks like a frame start or edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_h    <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_h  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
      cs_h    <= cs_s2;
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_h  <= sclk_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign cs_fall   = cs_h & ~cs_s2;
  assign cs_rise   = ~cs_h & cs_s2;
  assign sclk_fall = sclk_h & ~sclk_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      skip_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (dout_valid && dout_ready) dout_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            skip_cnt <= '0;
            bit_cnt  <= '0;
            state    <= (LEAD_SKIP == 0) ? SHIFT : SKIP;
          end
        end
        SKIP: begin
          if (cs_rise) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (sclk_fall) begin
            skip_cnt <= skip_cnt + 1'b1;
            if (skip_cnt == SKIP_LAST) state <= SHIFT;
          end
        end
        SHIFT: begin
          // A cs rise beats a coincident sclk fall: the partial word is discarded.
          if (cs_rise) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (sclk_fall) begin
            shift_reg <= {shift_reg[DATA_W-2:0], mosi_s2};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) state <= HOLD;
          end
        end
        HOLD: begin
          if (cs_rise) begin
            state <= IDLE;
            if (!dout_valid || dout_ready) begin
              dout       <= shift_reg;
              dout_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
